// File: rtl/conv_coeff_sched.sv
// conv_coeff_sched: coefficient scheduler for the 3x3 convolution datapath.
// The host writes a shadow bank; a commit swaps shadow into the active bank on
// the next frame boundary (vs_i falling edge). The active bank is streamed on
// coeff_o one tap per cycle, starting on the first vs_i-high cycle of a frame.
// Optional build macro CONV_COEFF_PRESET_EN: both banks reset to the identity
// kernel (centre tap = 1) instead of all zeros.
//
// state  | meaning
// IDLE   | after reset; wait for vs_i low so a partial frame is never streamed
// ARMED  | vs_i low; tap 0 preloaded on coeff_o, waiting for vs_i to rise
// STREAM | vs_i high; taps 1..N_COEFF-1 being driven
// DONE   | all taps driven; coeff_o held at 0 until vs_i falls
module conv_coeff_sched #(
  parameter int COEFF_W = 9,
  parameter int N_COEFF = 9,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [COEFF_W-1:0] wr_data_i,
  input  logic               commit_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [COEFF_W-1:0] rd_data_o,
  output logic [COEFF_W-1:0] coeff_o,
  output logic               pending_o,
  output logic               busy_o,
  output logic               load_done_o
);

  localparam int CNT_W = $clog2(N_COEFF + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_COEFF);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(N_COEFF);
  localparam int PRESET_IDX = N_COEFF / 2;

`ifdef CONV_COEFF_PRESET_EN
  localparam bit PRESET = 1'b1;
`else
  localparam bit PRESET = 1'b0;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [COEFF_W-1:0] shadow [N_COEFF];
  logic [COEFF_W-1:0] active [N_COEFF];
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               vs_q;
  logic               pending;
  logic               swap;
  logic               wr_ok;
  logic               rd_ok;
  logic [COEFF_W-1:0] next_active0;

  // Swaps happen only on a vs_i falling edge, so active is frozen while vs_i is high.
  assign swap         = pending & ~vs_i & vs_q;
  assign wr_ok        = wr_en_i & ({1'b0, wr_addr_i} < ADDR_LIM);
  assign rd_ok        = {1'b0, rd_addr_i} < ADDR_LIM;
  assign next_active0 = swap ? shadow[0] : active[0];
  assign pending_o    = pending;
  // High exactly during the vs-high cycles that carry taps 0..N_COEFF-1.
  assign busy_o       = vs_i & ((state == S_ARMED) | (state == S_STREAM));

  // Shadow bank: host writes, out-of-range addresses dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_COEFF; k++)
        shadow[k] <= (PRESET && k == PRESET_IDX) ? COEFF_W'(1) : '0;
    end else if (wr_ok) begin
      shadow[wr_addr_i] <= wr_data_i;
    end
  end

  // Active bank: whole-bank copy of the pre-write shadow on a committed boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_COEFF; k++)
        active[k] <= (PRESET && k == PRESET_IDX) ? COEFF_W'(1) : '0;
    end else if (swap) begin
      for (int k = 0; k < N_COEFF; k++)
        active[k] <= shadow[k];
    end
  end

  // vs_i delay for edge detect, and the commit-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q    <= 1'b0;
      pending <= 1'b0;
    end else begin
      vs_q <= vs_i;
      if (swap)
        pending <= commit_i;
      else if (commit_i)
        pending <= 1'b1;
    end
  end

  // Registered readback of the active bank; 0 outside the kernel.
  always_ff @(posedge clk) begin
    if (rst)
      rd_data_o <= '0;
    else
      rd_data_o <= rd_ok ? active[rd_addr_i] : '0;
  end

  // Stream sequencer. Tap 0 is preloaded while vs_i is low, so the rising
  // edge cycle already shows it and the transition edge loads tap 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      coeff_o     <= '0;
      load_done_o <= 1'b0;
    end else begin
      load_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          coeff_o <= '0;
          if (!vs_i) begin
            state   <= S_ARMED;
            coeff_o <= next_active0;
            cnt     <= CNT_W'(1);
          end
        end
        S_ARMED: begin
          if (vs_i) begin
            state   <= S_STREAM;
            coeff_o <= active[1];
            cnt     <= CNT_W'(2);
          end else begin
            coeff_o <= next_active0;
            cnt     <= CNT_W'(1);
          end
        end
        S_STREAM: begin
          if (!vs_i) begin
            // Frame ended early: drop the rest, no completion pulse.
            state   <= S_ARMED;
            coeff_o <= next_active0;
            cnt     <= CNT_W'(1);
          end else if (cnt == CNT_LAST) begin
            state       <= S_DONE;
            coeff_o     <= '0;
            cnt         <= '0;
            load_done_o <= 1'b1;
          end else begin
            coeff_o <= active[cnt];
            cnt     <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          coeff_o <= '0;
          if (!vs_i) begin
            state   <= S_ARMED;
            coeff_o <= next_active0;
            cnt     <= CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          coeff_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_coeff_sched.sv
// Directed bench for conv_coeff_sched: a cycle table for reset, the first
// frame and a write/commit/stream, then hand-written multi-frame sequences.
module tb_conv_coeff_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs_i;
  logic       wr_en_i;
  logic [3:0] wr_addr_i;
  logic [8:0] wr_data_i;
  logic       commit_i;
  logic [3:0] rd_addr_i;
  logic [8:0] rd_data_o;
  logic [8:0] coeff_o;
  logic       pending_o;
  logic       busy_o;
  logic       load_done_o;

`ifdef CONV_COEFF_PRESET_EN
  localparam logic [8:0] P4 = 9'd1;
`else
  localparam logic [8:0] P4 = 9'd0;
`endif

  typedef struct {
    logic       vs;
    logic       wr;
    logic [3:0] wa;
    logic [8:0] wd;
    logic       cm;
    logic [3:0] ra;
    logic [8:0] e_coeff;
    logic       e_busy;
    logic       e_done;
    logic       e_pend;
    logic [8:0] e_rd;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] exp_taps [9];
  int         n_tests = 0;
  int         n_fail  = 0;

  conv_coeff_sched dut (
    .clk         (clk),
    .rst         (rst),
    .vs_i        (vs_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .commit_i    (commit_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .coeff_o     (coeff_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o),
    .load_done_o (load_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic vs, input logic wr, input logic [3:0] wa,
                              input logic [8:0] wd, input logic cm, input logic [3:0] ra,
                              input logic [8:0] ec, input logic eb, input logic ed,
                              input logic ep, input logic [8:0] er);
    vec_t v;
    v.vs = vs; v.wr = wr; v.wa = wa; v.wd = wd; v.cm = cm; v.ra = ra;
    v.e_coeff = ec; v.e_busy = eb; v.e_done = ed; v.e_pend = ep; v.e_rd = er;
    tbl.push_back(v);
  endfunction

  // One frame: nlow vs-low cycles then nhigh vs-high cycles. At cycle act_at
  // an optional write and/or commit is applied. Taps come from exp_taps.
  task automatic frame(input int nlow, input int nhigh, input int act_at,
                       input logic a_wr, input logic [3:0] a_wa, input logic [8:0] a_wd,
                       input logic a_cm, input string nm);
    for (int c = 0; c < nlow + nhigh; c++) begin
      vs_i      = (c >= nlow);
      wr_en_i   = (c == act_at) && a_wr;
      wr_addr_i = a_wa;
      wr_data_i = a_wd;
      commit_i  = (c == act_at) && a_cm;
      #1;
      if (c < nlow) begin
        chk($sformatf("%s low%0d busy", nm, c), {31'd0, busy_o}, 32'd0);
        chk($sformatf("%s low%0d done", nm, c), {31'd0, load_done_o}, 32'd0);
      end else begin
        int i;
        logic [8:0] et;
        i  = c - nlow;
        et = 9'd0;
        if (i < 9) et = exp_taps[i];
        chk($sformatf("%s h%0d coeff", nm, i), {23'd0, coeff_o}, {23'd0, et});
        chk($sformatf("%s h%0d busy", nm, i), {31'd0, busy_o}, {31'd0, (i < 9)});
        chk($sformatf("%s h%0d done", nm, i), {31'd0, load_done_o}, {31'd0, (i == 9)});
      end
      tick();
    end
    wr_en_i  = 1'b0;
    commit_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vs_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    commit_i = 1'b0; rd_addr_i = '0;
    tick();
    tick();
    chk("rst coeff", {23'd0, coeff_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst done", {31'd0, load_done_o}, 32'd0);
    chk("rst pend", {31'd0, pending_o}, 32'd0);
    chk("rst rd", {23'd0, rd_data_o}, 32'd0);
    rst = 1'b0;

    // First frame after reset, no writes: vs low 3, high 12.
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, 4'd0, 9'd0, 1'b0, 4'd4, 9'd0, 1'b0, 1'b0, 1'b0, (i == 0) ? 9'd0 : P4);
    for (int n = 0; n < 12; n++)
      add(1'b1, 1'b0, 4'd0, 9'd0, 1'b0, 4'd4, (n == 4) ? P4 : 9'd0,
          (n < 9), (n == 9), 1'b0, P4);
    // Load shadow[k] = k+1 while the frame is still high, then commit.
    for (int k = 0; k < 9; k++)
      add(1'b1, 1'b1, 4'(k), 9'(k + 1), 1'b0, 4'd4, 9'd0, 1'b0, 1'b0, 1'b0, P4);
    add(1'b1, 1'b0, 4'd0, 9'd0, 1'b1, 4'd4, 9'd0, 1'b0, 1'b0, 1'b0, P4);
    // Boundary cycle: pending visible, swap at its closing edge.
    add(1'b0, 1'b0, 4'd0, 9'd0, 1'b0, 4'd8, 9'd0, 1'b0, 1'b0, 1'b1, P4);
    for (int n = 0; n < 11; n++)
      add(1'b1, 1'b0, 4'd0, 9'd0, 1'b0, 4'd8, (n < 9) ? 9'(n + 1) : 9'd0,
          (n < 9), (n == 9), 1'b0, (n == 0) ? 9'd0 : 9'd9);

    foreach (tbl[i]) begin
      vs_i = tbl[i].vs; wr_en_i = tbl[i].wr; wr_addr_i = tbl[i].wa;
      wr_data_i = tbl[i].wd; commit_i = tbl[i].cm; rd_addr_i = tbl[i].ra;
      #1;
      chk($sformatf("vec%0d coeff", i), {23'd0, coeff_o}, {23'd0, tbl[i].e_coeff});
      chk($sformatf("vec%0d busy", i), {31'd0, busy_o}, {31'd0, tbl[i].e_busy});
      chk($sformatf("vec%0d done", i), {31'd0, load_done_o}, {31'd0, tbl[i].e_done});
      chk($sformatf("vec%0d pend", i), {31'd0, pending_o}, {31'd0, tbl[i].e_pend});
      chk($sformatf("vec%0d rd", i), {23'd0, rd_data_o}, {23'd0, tbl[i].e_rd});
      tick();
    end
    wr_en_i = 1'b0; commit_i = 1'b0;

    for (int k = 0; k < 9; k++) exp_taps[k] = 9'(k + 1);

    // Write -1 into tap 4 and commit mid-stream: current frame unchanged.
    frame(1, 11, 3, 1'b1, 4'd4, 9'h1FF, 1'b1, "midwr");
    chk("midwr pend", {31'd0, pending_o}, 32'd1);
    exp_taps[4] = 9'h1FF;
    frame(1, 11, -1, 1'b0, 4'd0, 9'd0, 1'b0, "newk");
    chk("newk pend", {31'd0, pending_o}, 32'd0);

    // Commit in the swap cycle together with a write of shadow[0]=7.
    frame(1, 11, 6, 1'b1, 4'd8, 9'h020, 1'b1, "cm1");
    chk("cm1 pend", {31'd0, pending_o}, 32'd1);
    exp_taps[8] = 9'h020;
    frame(1, 11, 0, 1'b1, 4'd0, 9'd7, 1'b1, "swapcm");
    chk("swapcm pend", {31'd0, pending_o}, 32'd1);
    exp_taps[0] = 9'd7;
    frame(1, 11, -1, 1'b0, 4'd0, 9'd0, 1'b0, "second");
    chk("second pend", {31'd0, pending_o}, 32'd0);

    // Short frame aborts; the next full frame streams every tap.
    frame(1, 4, -1, 1'b0, 4'd0, 9'd0, 1'b0, "short");
    frame(1, 11, -1, 1'b0, 4'd0, 9'd0, 1'b0, "full");

    // Reset mid-stream, released with vs_i still high.
    frame(1, 3, -1, 1'b0, 4'd0, 9'd0, 1'b0, "prerst");
    rst = 1'b1;
    tick();
    chk("midrst coeff", {23'd0, coeff_o}, 32'd0);
    chk("midrst busy", {31'd0, busy_o}, 32'd0);
    chk("midrst pend", {31'd0, pending_o}, 32'd0);
    chk("midrst rd", {23'd0, rd_data_o}, 32'd0);
    tick();
    rst = 1'b0;
    wr_en_i = 1'b1; wr_addr_i = 4'd12; wr_data_i = 9'h1AB; commit_i = 1'b1; rd_addr_i = 4'd12;
    #1;
    chk("relhi0 busy", {31'd0, busy_o}, 32'd0);
    tick();
    wr_en_i = 1'b0; commit_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      #1;
      chk($sformatf("relhi%0d coeff", i), {23'd0, coeff_o}, 32'd0);
      chk($sformatf("relhi%0d busy", i), {31'd0, busy_o}, 32'd0);
      chk($sformatf("relhi%0d rd12", i), {23'd0, rd_data_o}, 32'd0);
      chk($sformatf("relhi%0d pend", i), {31'd0, pending_o}, 32'd1);
      tick();
    end
    for (int k = 0; k < 9; k++) exp_taps[k] = (k == 4) ? P4 : 9'd0;
    frame(1, 11, -1, 1'b0, 4'd0, 9'd0, 1'b0, "afterrst");
    chk("afterrst pend", {31'd0, pending_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
